rr_arb_sel: RTL
===============

Name: rr_arb_sel

Overview:
- Round-robin arbiter that sits directly upstream of the team's parameterised N:1 data mux.
- Accepts DEPTH requesters, each presenting BIT_WIDTH data on a packed bus.
- Picks one requester per transfer and drives the binary select index the mux consumes.
- Captures the winning word into a single-entry output register with a valid/ready handshake toward the downstream consumer.

Parameters:
- BIT_WIDTH, 8: width of each requester's data word.
- DEPTH, 2: number of requesters (≥2).
- SEL_WIDTH, ceil(log2(DEPTH)), minimum 1: width of the binary select index.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req, input, DEPTH: per-requester valid; bit i belongs to requester i.
- req_data, input, BIT_WIDTH*DEPTH: packed data; requester i occupies bits [BIT_WIDTH*i+BIT_WIDTH-1 : BIT_WIDTH*i].
- gnt, output, DEPTH: one-hot, combinational; gnt[i]=1 means requester i's word is captured at this clock edge.
- sel, output, SEL_WIDTH: registered binary index of the requester whose word is held in out_data.
- out_valid, output, 1: output register holds a word.
- out_data, output, BIT_WIDTH: held word.
- out_ready, input, 1: downstream accepts out_data this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, sel=0, priority pointer ptr=0.
  - gnt is all-zero while rst_n=0.
- Load condition: load = (|req) & (~out_valid | out_ready). It is a pass-through stage, so a word can be replaced in the same cycle it drains.
- Winner selection:
  - Winner w = first i with req[i]=1, scanning ptr, ptr+1, …, DEPTH-1, 0, …, ptr-1 (modulo DEPTH).
  - gnt = onehot(w) when load=1, else all-zero.
  - Exactly one gnt bit may be high; gnt never asserts for a requester with req=0.
- On a clock edge with load=1: out_data←req_data slice w; sel←w; out_valid←1; ptr←(w+1) mod DEPTH. Wrap: w=DEPTH-1 gives ptr=0.
- On a clock edge with out_valid & out_ready & ~load: out_valid←0; out_data and sel hold their last value.
- Output stalled (out_valid=1, out_ready=0): gnt all-zero; out_data, sel and ptr hold. Requesters must keep req and data stable until granted; the block does not buffer them.
- No requests: ptr holds; an idle cycle does not advance priority.
- Latency: a request granted in cycle N appears on out_valid/out_data in cycle N+1. Peak throughput is one word per cycle with out_ready held at 1.
- Fairness: a requester holding req continuously is granted within DEPTH loads.
- Non-power-of-two DEPTH: ptr and sel never take values ≥ DEPTH.
- Reset mid-transfer: the held word is discarded, out_valid drops immediately (asynchronously), and ptr returns to 0.
- State is the output register plus ptr; the FSM has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on load.
  - FULL→EMPTY on out_ready with no req.
  - FULL→FULL on load or stall.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 → out_valid=0, sel=0, out_data=0 with no clock edge needed; after release, first grant with req=2'b11 goes to requester 0.
- Round robin: DEPTH=4, BIT_WIDTH=8, req=4'b1111 held, data {8'h44,8'h33,8'h22,8'h11}, out_ready=1 → out_data sequence 11,22,33,44,11 on consecutive cycles; sel 0,1,2,3,0; out_valid stays high.
- Backpressure: out_ready=0 after first load → gnt=0, out_data stable for 5 cycles. Raise out_ready → next word loads in the same cycle the held one drains, with no bubble.
- Sparse requests: DEPTH=4, ptr=2, req=4'b0001 → requester 0 granted (wrap-around), ptr becomes 1. Then req=4'b0011 → requester 1 granted.
- Idle: req=0 for 3 cycles with out_ready=1 → out_valid falls one cycle after the last load, ptr unchanged, gnt=0.
- Non-power-of-two: DEPTH=3, SEL_WIDTH=2, all requesting → sel cycles 0,1,2,0 and never reaches 3.

Source files
------------

// File: rtl/rr_arb_sel.sv
// Round-robin arbiter feeding a single-entry output register with valid/ready.
// Drives the binary select index of the winning requester for the downstream N:1 mux.
module rr_arb_sel #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 2,
    parameter int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DEPTH-1:0]           req,
    input  logic [BIT_WIDTH*DEPTH-1:0] req_data,
    output logic [DEPTH-1:0]           gnt,
    output logic [SEL_WIDTH-1:0]       sel,
    output logic                       out_valid,
    output logic [BIT_WIDTH-1:0]       out_data,
    input  logic                       out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                           state, state_nxt;
    logic   [SEL_WIDTH-1:0]           ptr;
    logic   [SEL_WIDTH-1:0]           win;
    logic                             found;
    logic                             load;
    logic   [DEPTH-1:0][BIT_WIDTH-1:0] data_arr;

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign data_arr[i] = req_data[BIT_WIDTH*i +: BIT_WIDTH];
    end

    assign out_valid = (state == FULL);

    // Pass-through stage: a full register can be refilled in the cycle it drains.
    // Gating with rst_n keeps gnt quiet while reset is held.
    assign load = rst_n & (|req) & (~out_valid | out_ready);

    // Scan from ptr upward with modulo-DEPTH wrap; first requester found wins.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= DEPTH) idx = idx - DEPTH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = SEL_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (load) gnt[win] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (out_ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Data, index and priority only move on a load; a drain leaves them in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            sel      <= '0;
            ptr      <= '0;
        end else if (load) begin
            out_data <= data_arr[win];
            sel      <= win;
            ptr      <= (win == SEL_WIDTH'(DEPTH-1)) ? '0 : win + 1'b1;
        end
    end

endmodule
